// File: rtl/bus_ctrl.sv
// bus_ctrl: single-outstanding CPU load/store controller.
// Latches one request, looks it up through the external address decoder,
// then drives the selected device until it acks or the access times out.
// The CPU gets a one-cycle response strobe carrying read data or an error.
module bus_ctrl #(
  parameter int DATA_W  = 16,
  parameter int NUM_DEV = 7,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [15:0]               cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic                      cpu_ready,
  output logic                      cpu_rvalid,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_err,
  output logic                      dec_rd,
  output logic                      dec_wr,
  output logic [15:0]               dec_addr,
  input  logic                      dec_hit,
  input  logic [2:0]                dec_did,
  output logic [NUM_DEV-1:0]        dev_sel,
  output logic                      dev_we,
  output logic [11:0]               dev_addr,
  output logic [DATA_W-1:0]         dev_wdata,
  input  logic [NUM_DEV-1:0]        dev_ack,
  input  logic [NUM_DEV*DATA_W-1:0] dev_rdata
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, ACCESS, RESP} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [15:0]        addr_q, addr_nx;
  logic               we_q, we_nx;
  logic [DATA_W-1:0]  wdata_q, wdata_nx;
  logic [2:0]         did_q, did_nx;
  logic [DATA_W-1:0]  rdata_q, rdata_nx;
  logic               err_q, err_nx;

  logic               ack_hit;
  logic [DATA_W-1:0]  rdata_sel;
  logic [NUM_DEV-1:0] sel_oh;
  logic               lookup_ok;
  logic               in_xfer;

  // Device-slot mux: registered did picks its ack, read data and select bit.
  always_comb begin
    ack_hit   = 1'b0;
    rdata_sel = '0;
    sel_oh    = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (did_q == 3'(i)) begin
        ack_hit   = dev_ack[i];
        rdata_sel = dev_rdata[i*DATA_W +: DATA_W];
        sel_oh[i] = 1'b1;
      end
    end
  end

  // A decoder hit on a slot we do not implement is reported as a miss.
  assign lookup_ok = dec_hit && (int'(dec_did) < NUM_DEV);

  // Next-state and next-register logic for the transaction FSM.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr_q;
    we_nx    = we_q;
    wdata_nx = wdata_q;
    did_nx   = did_q;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          addr_nx  = cpu_addr;
          we_nx    = cpu_we;
          wdata_nx = cpu_wdata;
          state_nx = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lookup_ok) begin
          did_nx   = dec_did;
          cnt_nx   = '0;
          state_nx = ACCESS;
        end else begin
          err_nx   = 1'b1;
          rdata_nx = '0;
          state_nx = RESP;
        end
      end
      ACCESS: begin
        // An ack on the last allowed cycle still counts as success.
        if (ack_hit) begin
          err_nx   = 1'b0;
          rdata_nx = we_q ? '0 : rdata_sel;
          state_nx = RESP;
        end else if (cnt == CNT_LAST) begin
          err_nx   = 1'b1;
          rdata_nx = '0;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and latched request registers; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      did_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      addr_q  <= addr_nx;
      we_q    <= we_nx;
      wdata_q <= wdata_nx;
      did_q   <= did_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
    end
  end

  // Decoder strobes cover both LOOKUP and ACCESS so the decode stays stable.
  assign in_xfer    = (state == LOOKUP) || (state == ACCESS);
  assign cpu_ready  = (state == IDLE);
  assign cpu_rvalid = (state == RESP);
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;
  assign dec_rd     = in_xfer & ~we_q;
  assign dec_wr     = in_xfer & we_q;
  assign dec_addr   = addr_q;
  assign dev_sel    = (state == ACCESS) ? sel_oh : '0;
  assign dev_we     = (state == ACCESS) & we_q;
  assign dev_addr   = addr_q[11:0];
  assign dev_wdata  = wdata_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: directed bench for bus_ctrl with a decoder model, a
// programmable device responder and an in-order response scoreboard.
module tb_bus_ctrl;

  localparam int DATA_W  = 16;
  localparam int NUM_DEV = 7;
  localparam int TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      cpu_req;
  logic                      cpu_we;
  logic [15:0]               cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic                      cpu_ready;
  logic                      cpu_rvalid;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_err;
  logic                      dec_rd;
  logic                      dec_wr;
  logic [15:0]               dec_addr;
  logic                      dec_hit;
  logic [2:0]                dec_did;
  logic [NUM_DEV-1:0]        dev_sel;
  logic                      dev_we;
  logic [11:0]               dev_addr;
  logic [DATA_W-1:0]         dev_wdata;
  logic [NUM_DEV-1:0]        dev_ack;
  logic [NUM_DEV*DATA_W-1:0] dev_rdata;

  bus_ctrl #(.DATA_W(DATA_W), .NUM_DEV(NUM_DEV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_addr(dec_addr), .dec_hit(dec_hit), .dec_did(dec_did),
    .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_ack(dev_ack), .dev_rdata(dev_rdata)
  );

  always #5 clk = ~clk;

  // Decoder model: 4 KB slots, slot = addr[14:12]; upper half of the map misses.
  // 0x7000 hits slot 7, which the controller must treat as a miss.
  assign dec_hit = (dec_rd | dec_wr) && (dec_addr[15] == 1'b0);
  assign dec_did = dec_addr[14:12];

  // Fixed read data per device.
  logic [DATA_W-1:0] dev_data [NUM_DEV];
  initial begin
    dev_data[0] = 16'hBEEF;
    dev_data[1] = 16'h1111;
    dev_data[2] = 16'hA5C2;
    dev_data[3] = 16'h3C3C;
    dev_data[4] = 16'h4D4D;
    dev_data[5] = 16'h5A5A;
    dev_data[6] = 16'h6E6E;
  end
  always_comb begin
    for (int i = 0; i < NUM_DEV; i++) dev_rdata[i*DATA_W +: DATA_W] = dev_data[i];
  end

  // Responder: device ack_dev acks on its ack_after-th selected cycle (0 = never);
  // stray holds dev_ack[0] high regardless of selection.
  int ack_dev   = 0;
  int ack_after = 0;
  bit stray     = 1'b0;
  int acc_cyc   = 0;
  initial dev_ack = '0;
  always @(negedge clk) begin
    if (dev_sel != '0) acc_cyc = acc_cyc + 1;
    else acc_cyc = 0;
    dev_ack = '0;
    if (ack_after != 0 && dev_sel != '0 && acc_cyc == ack_after) dev_ack[ack_dev] = 1'b1;
    if (stray) dev_ack[0] = 1'b1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } resp_t;
  resp_t exp_q[$];

  // Monitor: every response strobe pops the oldest expectation.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && cpu_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'(cpu_rvalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", 32'(cpu_rdata), 32'(e.rdata));
        chk("resp_err", 32'(cpu_err), 32'(e.err));
      end
    end
  end

  // Called at a negedge: wait for ready, present the request, and return just
  // after the accepting edge with cpu_req dropped unless hold is set.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [DATA_W-1:0] wd,
                       input bit push, input logic [DATA_W-1:0] erd, input logic eerr,
                       input bit hold);
    int n = 0;
    while (!cpu_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ready) chk("ready_timeout", 32'(cpu_ready), 32'd1);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    if (push) exp_q.push_back('{rdata: erd, err: eerr});
    @(posedge clk);
    #1;
    if (!hold) cpu_req = 1'b0;
  endtask

  // Counts cycles from accept to the response strobe and checks the device
  // side along the way; returns at the following negedge (IDLE cycle).
  task automatic wait_resp(input string name, input logic we, input logic [15:0] addr,
                           input logic [DATA_W-1:0] wd, input int exp_lat,
                           input logic [NUM_DEV-1:0] exp_sel, input int exp_cyc);
    int k = 0;
    int cyc = 0;
    logic [NUM_DEV-1:0] sel_or = '0;
    bit seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk({name, "_dec_rd"}, 32'(dec_rd), 32'(!we));
        chk({name, "_dec_wr"}, 32'(dec_wr), 32'(we));
        chk({name, "_dec_addr"}, 32'(dec_addr), 32'(addr));
      end
      if (dev_sel != '0) begin
        cyc++;
        sel_or |= dev_sel;
        if (cyc == 1) begin
          chk({name, "_dev_we"}, 32'(dev_we), 32'(we));
          chk({name, "_dev_addr"}, 32'(dev_addr), 32'(addr[11:0]));
          if (we) chk({name, "_dev_wdata"}, 32'(dev_wdata), 32'(wd));
        end
      end
      if (cpu_rvalid) begin
        seen = 1'b1;
        chk({name, "_resp_sel_off"}, 32'(dev_sel), 32'd0);
        chk({name, "_resp_dec_off"}, 32'({dec_rd, dec_wr}), 32'd0);
      end
    end
    chk({name, "_latency"}, 32'(k), 32'(exp_lat));
    chk({name, "_sel"}, 32'(sel_or), 32'(exp_sel));
    chk({name, "_sel_cycles"}, 32'(cyc), 32'(exp_cyc));
    @(negedge clk);
    chk({name, "_ready_after"}, 32'({cpu_ready, cpu_rvalid}), 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_outs", 32'({cpu_rvalid, cpu_err, dev_we, dec_rd, dec_wr}), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_sel", 32'(dev_sel), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // DRAM read, ack in the first ACCESS cycle.
    ack_dev = 0; ack_after = 1;
    issue(1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    wait_resp("dram_rd", 1'b0, 16'h0010, 16'h0000, 3, 7'b0000001, 1);

    // DSPI write, ack on the third ACCESS cycle.
    ack_dev = 6; ack_after = 3;
    issue(1'b1, 16'h6FFF, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0);
    wait_resp("dspi_wr", 1'b1, 16'h6FFF, 16'h1234, 5, 7'b1000000, 3);

    // Misses: slot 7 and the upper half of the map.
    ack_after = 0;
    issue(1'b0, 16'h7000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_resp("miss_7000", 1'b0, 16'h7000, 16'h0000, 2, 7'b0000000, 0);
    issue(1'b0, 16'hF000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_resp("miss_f000", 1'b0, 16'hF000, 16'h0000, 2, 7'b0000000, 0);

    // DINT timeout, then ack on the final allowed cycle.
    ack_dev = 3; ack_after = 0;
    issue(1'b0, 16'h3000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_resp("dint_to", 1'b0, 16'h3000, 16'h0000, TIMEOUT + 2, 7'b0001000, TIMEOUT);
    ack_after = TIMEOUT;
    issue(1'b0, 16'h3000, 16'h0000, 1'b1, 16'h3C3C, 1'b0, 1'b0);
    wait_resp("dint_last", 1'b0, 16'h3000, 16'h0000, TIMEOUT + 2, 7'b0001000, TIMEOUT);

    // DMAT read with a stray DRAM ack and a second request held while busy.
    ack_dev = 2; ack_after = 2; stray = 1'b1;
    issue(1'b0, 16'h2000, 16'h0000, 1'b1, 16'hA5C2, 1'b0, 1'b1);
    cpu_we = 1'b1; cpu_addr = 16'h1004; cpu_wdata = 16'h5555;
    wait_resp("dmat_stray", 1'b0, 16'h2000, 16'h0000, 4, 7'b0000100, 2);
    stray = 1'b0; ack_dev = 1; ack_after = 1;
    chk("held_accept_ready", 32'({cpu_ready, cpu_req}), 32'b11);
    issue(1'b1, 16'h1004, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b0);
    wait_resp("drom_held", 1'b1, 16'h1004, 16'h5555, 3, 7'b0000010, 1);

    // Reset during a DREG access: no response, everything idle afterwards.
    ack_dev = 4; ack_after = 0;
    issue(1'b0, 16'h4000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_sel_before", 32'(dev_sel), 32'b0010000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_sel_after", 32'(dev_sel), 32'd0);
    chk("abort_ready", 32'(cpu_ready), 32'd1);
    chk("abort_quiet", 32'({cpu_rvalid, dec_rd, dec_wr}), 32'd0);
    ack_after = 2;
    issue(1'b0, 16'h4000, 16'h0000, 1'b1, 16'h4D4D, 1'b0, 1'b0);
    wait_resp("dreg_after", 1'b0, 16'h4000, 16'h0000, 4, 7'b0010000, 2);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
